// File: rtl/axis_row2block_pkg.sv
// Shared constants, phase type and helpers for the row-major to 2x2-block stream converter.
package axis_row2block_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned BLOCK_SIZE = 2;
    localparam int unsigned CHUNK_SIZE = BLOCK_SIZE * BLOCK_SIZE;

    // Element positions inside one 2x2 chunk: a(r,c) | a(r,c+1) | a(r+1,c) | a(r+1,c+1)
    localparam int unsigned A00_MSB = 4 * WIDTH - 1;
    localparam int unsigned A00_LSB = 3 * WIDTH;
    localparam int unsigned A01_MSB = 3 * WIDTH - 1;
    localparam int unsigned A01_LSB = 2 * WIDTH;
    localparam int unsigned A10_MSB = 2 * WIDTH - 1;
    localparam int unsigned A10_LSB = WIDTH;
    localparam int unsigned A11_MSB = WIDTH - 1;
    localparam int unsigned A11_LSB = 0;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_row2block_if.sv
// Minimal AXI-Stream bundle used on both sides of the row-to-block converter.
interface axis_row2block_if #(
    parameter int unsigned DATA_W = 32
);

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_row2block_row_line_buf.sv
// One-row line buffer: synchronous write, combinational read, no reset so it maps to LUTRAM/BRAM.
module axis_row2block_row_line_buf #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 1
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_row2block.sv
// Row-major pair stream in, 2x2 block chunks out; the even row of each pair is parked in a line buffer.
// Optional tlast framing check and resync: define AXIS_ROW2BLOCK_TLAST_CHECK_EN.
module axis_row2block #(
    parameter int unsigned WIDTH = axis_row2block_pkg::WIDTH,
    parameter int unsigned COLS  = 4,
    parameter int unsigned ROWS  = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    axis_row2block_if.slave  s_axis,
    axis_row2block_if.master m_axis
`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
    ,
    output logic             err_tlast
`endif
);

    import axis_row2block_pkg::*;

    localparam int unsigned PAIRS = COLS / 2;
    localparam int unsigned CW    = (PAIRS > 1) ? clog2(PAIRS) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? clog2(ROWS) : 1;
    localparam int unsigned BW    = 2 * WIDTH;
    localparam int unsigned OW    = 4 * WIDTH;

    logic [CW-1:0] col_cnt, col_cnt_nxt;
    logic [RW-1:0] row_cnt, row_cnt_nxt;
    logic [OW-1:0] out_data, out_data_nxt;
    logic          out_valid, out_valid_nxt;
    logic          out_last, out_last_nxt;
    logic [BW-1:0] line_rd;
    phase_e        phase;

    logic s_ready_c;
    logic s_fire_c;
    logic at_end_c;
    logic drop_c;
    logic load_c;
    logic wr_en_c;

`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
    logic err_nxt;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
`endif

    assign phase = phase_e'(row_cnt[0]);

    // Next-state: counters, output register and framing check
    always_comb begin
        col_cnt_nxt   = col_cnt;
        row_cnt_nxt   = row_cnt;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        drop_c        = 1'b0;

        s_ready_c = (phase == PH_EVEN) || !out_valid || m_axis.tready;
        s_fire_c  = s_axis.tvalid && s_ready_c;
        at_end_c  = (row_cnt == RW'(ROWS - 1)) && (col_cnt == CW'(PAIRS - 1));

`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
        err_nxt = err_tlast || (s_fire_c && (s_axis.tlast != at_end_c));
        drop_c  = s_fire_c && s_axis.tlast && !at_end_c;
`endif

        load_c  = s_fire_c && (phase == PH_ODD) && !drop_c;
        wr_en_c = s_fire_c && (phase == PH_EVEN);

        if (m_axis.tready) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
        end
        if (load_c) begin
            out_valid_nxt = 1'b1;
            out_data_nxt  = {line_rd, s_axis.tdata};
            out_last_nxt  = at_end_c;
        end

        if (s_fire_c) begin
            if (drop_c) begin
                col_cnt_nxt = '0;
                row_cnt_nxt = '0;
            end else if (col_cnt == CW'(PAIRS - 1)) begin
                col_cnt_nxt = '0;
                row_cnt_nxt = (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt_nxt = col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
            err_tlast <= 1'b0;
`endif
        end else begin
            col_cnt   <= col_cnt_nxt;
            row_cnt   <= row_cnt_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
            err_tlast <= err_nxt;
`endif
        end
    end

    axis_row2block_row_line_buf #(
        .DEPTH  (PAIRS),
        .DATA_W (BW),
        .AW     (CW)
    ) u_line_buf (
        .aclk    (aclk),
        .wr_en   (wr_en_c),
        .wr_addr (col_cnt),
        .wr_data (s_axis.tdata),
        .rd_addr (col_cnt),
        .rd_data (line_rd)
    );

    assign s_axis.tready = s_ready_c;
    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;

endmodule

// File: tb/tb_axis_row2block.sv
// Directed bench for axis_row2block: 8x4 instance for streaming/stall/reset cases, 2x64 instance for the wide row.
module tb_axis_row2block;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    axis_row2block_if #(.DATA_W(32)) s_if ();
    axis_row2block_if #(.DATA_W(64)) m_if ();
    axis_row2block_if #(.DATA_W(32)) s2_if ();
    axis_row2block_if #(.DATA_W(64)) m2_if ();

`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
    logic err_tlast;
    logic err_tlast2;
`endif

    axis_row2block #(.WIDTH(16), .COLS(4), .ROWS(8)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axis  (s_if),
        .m_axis  (m_if)
`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
        ,
        .err_tlast (err_tlast)
`endif
    );

    axis_row2block #(.WIDTH(16), .COLS(64), .ROWS(2)) dut_wide (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axis  (s2_if),
        .m_axis  (m2_if)
`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
        ,
        .err_tlast (err_tlast2)
`endif
    );

    typedef struct {
        int          row;
        int          col;
        logic [63:0] data;
        logic        last;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } chunk_t;

    vec_t   tbl [8];
    chunk_t got[$];
    chunk_t got2[$];

    int          n_vec = 0;
    int          n_bad = 0;
    int          beat_idx, beat_base, beat_total, force_pos;
    bit          last_fire, prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Element value at stream position p (relative to matrix start): m*256 + 16*r + c
    function automatic logic [31:0] beat_data(input int p);
        int m, q, r, c, e;
        m = p / 16;
        q = p % 16;
        r = q / 2;
        c = (q % 2) * 2;
        e = m * 256 + 16 * r + c;
        return {16'(e), 16'(e + 1)};
    endfunction

    // One cycle: drive at the falling edge, observe settled signals before the rising edge
    task automatic step(input int pv, input int pr);
        bit keep;
        @(negedge aclk);
        keep = s_if.tvalid && !last_fire;
        if (!keep) begin
            s_if.tvalid = (beat_idx < beat_total) && (int'($urandom_range(99)) < pv);
        end
        s_if.tdata  = beat_data(beat_idx - beat_base);
        s_if.tlast  = ((beat_idx - beat_base) % 16 == 15) || ((beat_idx - beat_base) == force_pos);
        m_if.tready = (int'($urandom_range(99)) < pr);
        #1;
        if (prev_stall) begin
            chk("hold_valid", 64'(m_if.tvalid), 64'(1));
            chk("hold_data", m_if.tdata, prev_data);
            chk("hold_last", 64'(m_if.tlast), 64'(prev_last));
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        prev_last  = m_if.tlast;
        last_fire  = s_if.tvalid && s_if.tready;
        if (last_fire) beat_idx++;
        if (m_if.tvalid && m_if.tready) got.push_back('{m_if.tdata, m_if.tlast});
    endtask

    task automatic run(input int pv, input int pr);
        int budget;
        budget = 3000;
        while (1) begin
            step(pv, pr);
            if (beat_idx == beat_total && !last_fire && !m_if.tvalid) break;
            budget--;
            if (budget == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL run_timeout: got %0d beats, want %0d", beat_idx, beat_total);
                break;
            end
        end
    endtask

    task automatic check_chunks(input int n, input int mat0);
        logic [63:0] exp;
        chk("chunk_count", 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            exp = tbl[i % 8].data + 64'(mat0 + i / 8) * 64'h0100_0100_0100_0100;
            chk($sformatf("chunk%0d_data(r%0d,c%0d)", i, tbl[i % 8].row, tbl[i % 8].col), got[i].data, exp);
            chk($sformatf("chunk%0d_last", i), 64'(got[i].last), 64'(tbl[i % 8].last));
        end
    endtask

    task automatic do_reset();
        s_if.tvalid  = 1'b0;
        s_if.tlast   = 1'b0;
        s_if.tdata   = '0;
        m_if.tready  = 1'b0;
        s2_if.tvalid = 1'b0;
        s2_if.tlast  = 1'b0;
        s2_if.tdata  = '0;
        m2_if.tready = 1'b0;
        aresetn      = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn    = 1'b1;
        beat_idx   = 0;
        beat_base  = 0;
        beat_total = 0;
        force_pos  = -1;
        last_fire  = 1'b0;
        prev_stall = 1'b0;
        got.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int j, rdy_cnt, last_cnt;
        logic [63:0] exp2;

        tbl[0] = '{0, 0, 64'h0000_0001_0010_0011, 1'b0};
        tbl[1] = '{0, 2, 64'h0002_0003_0012_0013, 1'b0};
        tbl[2] = '{2, 0, 64'h0020_0021_0030_0031, 1'b0};
        tbl[3] = '{2, 2, 64'h0022_0023_0032_0033, 1'b0};
        tbl[4] = '{4, 0, 64'h0040_0041_0050_0051, 1'b0};
        tbl[5] = '{4, 2, 64'h0042_0043_0052_0053, 1'b0};
        tbl[6] = '{6, 0, 64'h0060_0061_0070_0071, 1'b0};
        tbl[7] = '{6, 2, 64'h0062_0063_0072_0073, 1'b1};

        // Reset state
        do_reset();
        @(negedge aclk);
        #1;
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        chk("rst_m_tlast", 64'(m_if.tlast), 64'(0));
        chk("rst_m_tdata", m_if.tdata, 64'(0));
        chk("rst_s_tready", 64'(s_if.tready), 64'(1));

        // Full-rate single matrix
        beat_total = 16;
        run(100, 100);
        check_chunks(8, 0);

        // Output stall during the first odd row
        do_reset();
        beat_total = 16;
        repeat (3) step(100, 0);
        step(100, 0);
        chk("stall_m_tvalid", 64'(m_if.tvalid), 64'(1));
        chk("stall_s_tready", 64'(s_if.tready), 64'(0));
        chk("stall_m_tdata", m_if.tdata, tbl[0].data);
        repeat (2) step(100, 0);
        chk("stall_beats", 64'(beat_idx), 64'(3));
        run(100, 100);
        check_chunks(8, 0);

        // Three back-to-back matrices under random valid/ready
        beat_base  = beat_idx;
        beat_total = beat_idx + 48;
        got.delete();
        run(50, 50);
        check_chunks(24, 0);

        // Asynchronous reset with a chunk pending in the output register
        beat_base  = beat_idx;
        beat_total = beat_idx + 16;
        got.delete();
        for (int k = 0; k < 200 && (beat_idx - beat_base) < 7; k++) begin
            step(100, ((beat_idx - beat_base) < 6) ? 100 : 0);
        end
        step(0, 0);
        chk("pre_rst_m_tvalid", 64'(m_if.tvalid), 64'(1));
        chk("pre_rst_chunks", 64'(got.size()), 64'(2));
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        @(negedge aclk);
        aresetn    = 1'b1;
        beat_idx   = 0;
        beat_base  = 0;
        beat_total = 16;
        last_fire  = 1'b0;
        prev_stall = 1'b0;
        got.delete();
        #1;
        chk("post_rst_s_tready", 64'(s_if.tready), 64'(1));
        run(100, 100);
        check_chunks(8, 0);

`ifdef AXIS_ROW2BLOCK_TLAST_CHECK_EN
        // Early tlast: flag, resync, drop the partial pair
        chk("err_clear", 64'(err_tlast), 64'(0));
        beat_base  = beat_idx;
        force_pos  = 9;
        beat_total = beat_idx + 10;
        got.delete();
        run(100, 100);
        chk("err_set", 64'(err_tlast), 64'(1));
        check_chunks(4, 0);
        force_pos  = -1;
        beat_base  = beat_idx;
        beat_total = beat_idx + 16;
        got.delete();
        run(100, 100);
        check_chunks(8, 0);
        chk("err_sticky", 64'(err_tlast), 64'(1));
`endif

        // Wide row: 2 rows x 64 columns, one beat per cycle
        j        = 0;
        rdy_cnt  = 0;
        last_cnt = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge aclk);
            s2_if.tvalid = (j < 64);
            s2_if.tdata  = (j < 32) ? {16'(2 * j), 16'(2 * j + 1)}
                                    : {16'(256 + 2 * (j - 32)), 16'(257 + 2 * (j - 32))};
            s2_if.tlast  = (j == 63);
            m2_if.tready = 1'b1;
            #1;
            if (s2_if.tvalid && (j < 32) && s2_if.tready) rdy_cnt++;
            if (s2_if.tvalid && s2_if.tready) j++;
            if (m2_if.tvalid) got2.push_back('{m2_if.tdata, m2_if.tlast});
        end
        s2_if.tvalid = 1'b0;
        chk("wide_even_ready", 64'(rdy_cnt), 64'(32));
        chk("wide_chunk_count", 64'(got2.size()), 64'(32));
        for (int k = 0; k < 32 && k < got2.size(); k++) begin
            exp2 = {16'(2 * k), 16'(2 * k + 1), 16'(256 + 2 * k), 16'(257 + 2 * k)};
            chk($sformatf("wide_chunk%0d", k), got2[k].data, exp2);
            if (got2[k].last) last_cnt++;
        end
        chk("wide_tlast_count", 64'(last_cnt), 64'(1));
        if (got2.size() == 32) chk("wide_tlast_pos", 64'(got2[31].last), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
